// File: rtl/xpsr_pkg.sv
// Shared field widths, bit positions, context type and IT-state helper for
// the xPSR register with hardware exception frame stack.
package xpsr_pkg;

    localparam int unsigned APSR_W       = 5;   // {N,Z,C,V,Q}
    localparam int unsigned GE_W         = 4;
    localparam int unsigned IT_W         = 8;
    localparam int unsigned EPSR_W       = 10;  // {T, 1'b0, IT[7:0]}
    localparam int unsigned FLAG_W       = 4;   // {N,Z,C,V}
    localparam int unsigned MSR_APSR_LSB = 27;  // msr_data[31:27] = {N,Z,C,V,Q}
    localparam int unsigned MSR_GE_LSB   = 16;  // msr_data[19:16] = GE
    localparam int unsigned APSR_Q_BIT   = 0;

    localparam logic T_RST = 1'b1;

    // Architectural state carried in a frame apart from the exception number,
    // whose width is a parameter of the top level.
    typedef struct packed {
        logic [APSR_W-1:0] apsr;
        logic [GE_W-1:0]   ge;
        logic [IT_W-1:0]   it;
        logic              t;
    } xpsr_ctx_t;

    // Step the IT block: finished when the mask bits run out, else shift mask.
    function automatic logic [IT_W-1:0] it_advance(input logic [IT_W-1:0] it);
        logic [IT_W-1:0] nxt;
        nxt = it;
        if (it[2:0] == 3'b000) begin
            nxt = '0;
        end else begin
            nxt[4:0] = {it[3:0], 1'b0};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/xpsr_frame_stack.sv
// Parametrised LIFO used to hold saved xPSR frames.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_pop, i_data,
//        o_data (top of stack, undefined while empty), o_depth, o_full, o_empty.
module xpsr_frame_stack #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_depth;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_top;

    assign o_full    = (r_depth == DW'(DEPTH));
    assign o_empty   = (r_depth == '0);
    assign w_do_push = i_push && !i_pop && !o_full;
    assign w_do_pop  = i_pop && !i_push && !o_empty;
    assign w_top     = AW'(r_depth - DW'(1));

    // Occupancy counter; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + DW'(1);
        end else if (w_do_pop) begin
            r_depth <= r_depth - DW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[AW'(r_depth)] <= i_data;
        end
    end

    assign o_data  = r_mem[w_top];
    assign o_depth = r_depth;

endmodule

// File: rtl/xpsr_stack_reg.sv
// Program status register (APSR, GE, IPSR, EPSR) with a hardware frame stack
// for nested exceptions, including tail-chain handling.
// Inputs : retire-stage updates (flags, Q, MSR, GE, IT load/advance) and
//          exception entry/return with exception number.
// Outputs: registered apsr/ge/ipsr/epsr, in_it, stack depth/full/empty and
//          one-cycle overflow/underflow error pulses.
module xpsr_stack_reg
    import xpsr_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned EXC_W = 9,
    parameter int unsigned GE_EN = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_inst_valid,
    input  logic                         i_flag_we,
    input  logic [FLAG_W-1:0]            i_flag_mask,
    input  logic [FLAG_W-1:0]            i_flag_in,
    input  logic                         i_q_set,
    input  logic                         i_msr_we,
    input  logic [31:0]                  i_msr_data,
    input  logic                         i_ge_we,
    input  logic [GE_W-1:0]              i_ge_in,
    input  logic                         i_it_load,
    input  logic [IT_W-1:0]              i_it_in,
    input  logic                         i_exc_entry,
    input  logic [EXC_W-1:0]             i_exc_num,
    input  logic                         i_exc_return,
    output logic [APSR_W-1:0]            o_apsr,
    output logic [GE_W-1:0]              o_ge,
    output logic [EXC_W-1:0]             o_ipsr,
    output logic [EPSR_W-1:0]            o_epsr,
    output logic                         o_in_it,
    output logic [$clog2(DEPTH+1)-1:0]   o_depth,
    output logic                         o_stack_full,
    output logic                         o_stack_empty,
    output logic                         o_ovf_err,
    output logic                         o_unf_err
);

    // Frame layout, MSB first: {apsr, ge, ipsr, IT, T}
    localparam int unsigned FRAME_W = APSR_W + GE_W + EXC_W + IT_W + 1;

    logic [APSR_W-1:0] r_apsr;
    logic [GE_W-1:0]   r_ge;
    logic [EXC_W-1:0]  r_ipsr;
    logic [IT_W-1:0]   r_it;
    logic              r_t;
    logic              r_ovf;
    logic              r_unf;

    xpsr_ctx_t         w_nx;
    xpsr_ctx_t         w_pop_ctx;
    logic [EXC_W-1:0]  w_pop_ipsr;
    logic [FRAME_W-1:0] w_push_frame;
    logic [FRAME_W-1:0] w_pop_frame;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_tail;
    logic              w_ovf;
    logic              w_unf;
    logic              w_unused_msr;

    assign w_unused_msr = ^{i_msr_data[26:20], i_msr_data[15:0], i_ge_in};

    // Merged next state from retire-stage updates, before exception handling.
    always_comb begin
        w_nx.apsr = r_apsr;
        w_nx.ge   = r_ge;
        w_nx.it   = r_it;
        w_nx.t    = r_t;
        if (i_msr_we) begin
            w_nx.apsr = i_msr_data[MSR_APSR_LSB +: APSR_W];
        end
        if (i_flag_we) begin
            w_nx.apsr[APSR_W-1:1] = (w_nx.apsr[APSR_W-1:1] & ~i_flag_mask)
                                  | (i_flag_in & i_flag_mask);
        end
        if (i_q_set) begin
            w_nx.apsr[APSR_Q_BIT] = 1'b1;
        end
        if (GE_EN != 0) begin
            if (i_ge_we) begin
                w_nx.ge = i_ge_in;
            end else if (i_msr_we) begin
                w_nx.ge = i_msr_data[MSR_GE_LSB +: GE_W];
            end
        end else begin
            w_nx.ge = '0;
        end
        if (i_it_load) begin
            w_nx.it = i_it_in;
        end else if (i_inst_valid) begin
            w_nx.it = it_advance(r_it);
        end
    end

    // Exception event decode; guarding keeps the stack from over/underflowing.
    assign w_push = i_exc_entry && !i_exc_return && !w_full;
    assign w_pop  = i_exc_return && !i_exc_entry && !w_empty;
    assign w_tail = i_exc_entry && i_exc_return && !w_empty;
    assign w_ovf  = i_exc_entry && !i_exc_return && w_full;
    assign w_unf  = i_exc_return && w_empty;

    assign w_push_frame = {w_nx.apsr, w_nx.ge, r_ipsr, w_nx.it, w_nx.t};

    assign w_pop_ctx.apsr = w_pop_frame[FRAME_W-1 -: APSR_W];
    assign w_pop_ctx.ge   = w_pop_frame[FRAME_W-APSR_W-1 -: GE_W];
    assign w_pop_ipsr     = w_pop_frame[IT_W+1 +: EXC_W];
    assign w_pop_ctx.it   = w_pop_frame[1 +: IT_W];
    assign w_pop_ctx.t    = w_pop_frame[0];

    xpsr_frame_stack #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_frame),
        .o_data  (w_pop_frame),
        .o_depth (o_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Live register update; a faulting exception event leaves state untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_apsr <= '0;
            r_ge   <= '0;
            r_ipsr <= '0;
            r_it   <= '0;
            r_t    <= T_RST;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_ovf <= w_ovf;
            r_unf <= w_unf;
            if (w_pop) begin
                r_apsr <= w_pop_ctx.apsr;
                r_ge   <= w_pop_ctx.ge;
                r_ipsr <= w_pop_ipsr;
                r_it   <= w_pop_ctx.it;
                r_t    <= w_pop_ctx.t;
            end else if (w_push) begin
                r_apsr <= w_nx.apsr;
                r_ge   <= w_nx.ge;
                r_ipsr <= i_exc_num;
                r_it   <= '0;
                r_t    <= 1'b1;
            end else if (w_tail) begin
                r_apsr <= w_nx.apsr;
                r_ge   <= w_nx.ge;
                r_ipsr <= i_exc_num;
                r_it   <= '0;
            end else if (!i_exc_entry && !i_exc_return) begin
                r_apsr <= w_nx.apsr;
                r_ge   <= w_nx.ge;
                r_it   <= w_nx.it;
            end
        end
    end

    assign o_apsr        = r_apsr;
    assign o_ge          = r_ge;
    assign o_ipsr        = r_ipsr;
    assign o_epsr        = {r_t, 1'b0, r_it};
    assign o_in_it       = |r_it[3:0];
    assign o_stack_full  = w_full;
    assign o_stack_empty = w_empty;
    assign o_ovf_err     = r_ovf;
    assign o_unf_err     = r_unf;

endmodule

// File: tb/tb_xpsr_stack_reg.sv
// Directed self-checking bench for xpsr_stack_reg: a DEPTH=8 instance for
// the main function and a DEPTH=2 instance for stack limits, sharing inputs.
module tb_xpsr_stack_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, flag_we, q_set, msr_we, ge_we, it_load;
    logic        exc_entry, exc_return;
    logic [3:0]  flag_mask, flag_in, ge_in;
    logic [31:0] msr_data;
    logic [7:0]  it_in;
    logic [8:0]  exc_num;

    logic [4:0]  a_apsr, b_apsr;
    logic [3:0]  a_ge, b_ge;
    logic [8:0]  a_ipsr, b_ipsr;
    logic [9:0]  a_epsr, b_epsr;
    logic        a_in_it, b_in_it;
    logic [3:0]  a_depth;
    logic [1:0]  b_depth;
    logic        a_full, a_empty, a_ovf, a_unf;
    logic        b_full, b_empty, b_ovf, b_unf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xpsr_stack_reg #(.DEPTH(8), .EXC_W(9), .GE_EN(1)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_inst_valid(inst_valid), .i_flag_we(flag_we),
        .i_flag_mask(flag_mask), .i_flag_in(flag_in), .i_q_set(q_set),
        .i_msr_we(msr_we), .i_msr_data(msr_data), .i_ge_we(ge_we), .i_ge_in(ge_in),
        .i_it_load(it_load), .i_it_in(it_in), .i_exc_entry(exc_entry),
        .i_exc_num(exc_num), .i_exc_return(exc_return),
        .o_apsr(a_apsr), .o_ge(a_ge), .o_ipsr(a_ipsr), .o_epsr(a_epsr),
        .o_in_it(a_in_it), .o_depth(a_depth), .o_stack_full(a_full),
        .o_stack_empty(a_empty), .o_ovf_err(a_ovf), .o_unf_err(a_unf)
    );

    xpsr_stack_reg #(.DEPTH(2), .EXC_W(9), .GE_EN(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_inst_valid(inst_valid), .i_flag_we(flag_we),
        .i_flag_mask(flag_mask), .i_flag_in(flag_in), .i_q_set(q_set),
        .i_msr_we(msr_we), .i_msr_data(msr_data), .i_ge_we(ge_we), .i_ge_in(ge_in),
        .i_it_load(it_load), .i_it_in(it_in), .i_exc_entry(exc_entry),
        .i_exc_num(exc_num), .i_exc_return(exc_return),
        .o_apsr(b_apsr), .o_ge(b_ge), .o_ipsr(b_ipsr), .o_epsr(b_epsr),
        .o_in_it(b_in_it), .o_depth(b_depth), .o_stack_full(b_full),
        .o_stack_empty(b_empty), .o_ovf_err(b_ovf), .o_unf_err(b_unf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        inst_valid = 1'b0; flag_we = 1'b0; q_set = 1'b0; msr_we = 1'b0;
        ge_we = 1'b0; it_load = 1'b0; exc_entry = 1'b0; exc_return = 1'b0;
        flag_mask = '0; flag_in = '0; ge_in = '0; msr_data = '0;
        it_in = '0; exc_num = '0;
    endtask

    // One clock: inputs set beforehand are sampled, then cleared 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        do_reset();

        // Reset state
        check_eq("rst_epsr",  32'(a_epsr),  32'h200);
        check_eq("rst_apsr",  32'(a_apsr),  32'h0);
        check_eq("rst_ge",    32'(a_ge),    32'h0);
        check_eq("rst_ipsr",  32'(a_ipsr),  32'h0);
        check_eq("rst_in_it", 32'(a_in_it), 32'h0);
        check_eq("rst_depth", 32'(a_depth), 32'h0);
        check_eq("rst_empty", 32'(a_empty), 32'h1);
        check_eq("rst_full",  32'(a_full),  32'h0);
        check_eq("rst_errs",  32'({a_ovf, a_unf}), 32'h0);
        tick();
        check_eq("idle_epsr", 32'(a_epsr),  32'h200);

        // IT load and advance
        it_load = 1'b1; it_in = 8'h0C; tick();
        check_eq("it_load",    32'(a_epsr),  32'h20C);
        check_eq("it_load_in", 32'(a_in_it), 32'h1);
        inst_valid = 1'b1; tick();
        check_eq("it_adv1",    32'(a_epsr),  32'h218);
        check_eq("it_adv1_in", 32'(a_in_it), 32'h1);
        inst_valid = 1'b1; tick();
        check_eq("it_adv2",    32'(a_epsr),  32'h200);
        check_eq("it_adv2_in", 32'(a_in_it), 32'h0);

        // Flag merge order and GE priority
        msr_we = 1'b1; msr_data = 32'hF800_0000;
        flag_we = 1'b1; flag_mask = 4'b0101; flag_in = 4'b0000; tick();
        check_eq("merge_apsr", 32'(a_apsr), 32'h15);
        q_set = 1'b1; tick();
        check_eq("q_sticky",   32'(a_apsr), 32'h15);
        msr_we = 1'b1; msr_data = 32'h000A_0000; ge_we = 1'b1; ge_in = 4'h5; tick();
        check_eq("ge_we_wins", 32'(a_ge),   32'h5);
        check_eq("msr_clr",    32'(a_apsr), 32'h0);
        msr_we = 1'b1; msr_data = 32'h000F_0000; tick();
        check_eq("ge_msr",     32'(a_ge),   32'hF);
        flag_we = 1'b1; flag_mask = 4'b1111; flag_in = 4'b1010; tick();
        check_eq("flag_full",  32'(a_apsr), 32'h14);

        // Nesting: three entries then three returns
        do_reset();
        it_load = 1'b1; it_in = 8'h0C; tick();
        exc_entry = 1'b1; exc_num = 9'd11; inst_valid = 1'b1;
        flag_we = 1'b1; flag_mask = 4'b1000; flag_in = 4'b1000; tick();
        check_eq("n1_ipsr",  32'(a_ipsr),  32'd11);
        check_eq("n1_depth", 32'(a_depth), 32'd1);
        check_eq("n1_apsr",  32'(a_apsr),  32'h10);
        check_eq("n1_epsr",  32'(a_epsr),  32'h200);
        exc_entry = 1'b1; exc_num = 9'd15;
        flag_we = 1'b1; flag_mask = 4'b0100; flag_in = 4'b0100; tick();
        check_eq("n2_ipsr",  32'(a_ipsr),  32'd15);
        check_eq("n2_apsr",  32'(a_apsr),  32'h18);
        exc_entry = 1'b1; exc_num = 9'd16; q_set = 1'b1; tick();
        check_eq("n3_ipsr",  32'(a_ipsr),  32'd16);
        check_eq("n3_depth", 32'(a_depth), 32'd3);
        check_eq("n3_apsr",  32'(a_apsr),  32'h19);
        msr_we = 1'b1; msr_data = 32'h0; tick();
        check_eq("n3_clr",   32'(a_apsr),  32'h0);
        exc_return = 1'b1; flag_we = 1'b1; flag_mask = 4'hF; flag_in = 4'hF; tick();
        check_eq("r1_ipsr",  32'(a_ipsr),  32'd15);
        check_eq("r1_apsr",  32'(a_apsr),  32'h19);
        check_eq("r1_depth", 32'(a_depth), 32'd2);
        exc_return = 1'b1; tick();
        check_eq("r2_ipsr",  32'(a_ipsr),  32'd11);
        check_eq("r2_apsr",  32'(a_apsr),  32'h18);
        exc_return = 1'b1; tick();
        check_eq("r3_ipsr",  32'(a_ipsr),  32'd0);
        check_eq("r3_apsr",  32'(a_apsr),  32'h10);
        check_eq("r3_epsr",  32'(a_epsr),  32'h218);
        check_eq("r3_empty", 32'(a_empty), 32'h1);

        // Tail-chain
        exc_entry = 1'b1; exc_num = 9'd11; tick();
        check_eq("tc_pre_ipsr", 32'(a_ipsr), 32'd11);
        exc_entry = 1'b1; exc_return = 1'b1; exc_num = 9'd14;
        flag_we = 1'b1; flag_mask = 4'hF; flag_in = 4'b0001; tick();
        check_eq("tc_ipsr",  32'(a_ipsr),  32'd14);
        check_eq("tc_depth", 32'(a_depth), 32'd1);
        check_eq("tc_apsr",  32'(a_apsr),  32'h02);
        check_eq("tc_unf",   32'(a_unf),   32'h0);
        exc_return = 1'b1; tick();
        check_eq("tc_ret_ipsr",  32'(a_ipsr),  32'd0);
        check_eq("tc_ret_depth", 32'(a_depth), 32'd0);
        check_eq("tc_ret_apsr",  32'(a_apsr),  32'h10);
        check_eq("tc_ret_epsr",  32'(a_epsr),  32'h218);

        // Limits on the DEPTH=2 instance
        do_reset();
        exc_entry = 1'b1; exc_num = 9'd1; tick();
        exc_entry = 1'b1; exc_num = 9'd2; tick();
        check_eq("lim_depth", 32'(b_depth), 32'd2);
        check_eq("lim_full",  32'(b_full),  32'h1);
        exc_entry = 1'b1; exc_num = 9'd3;
        flag_we = 1'b1; flag_mask = 4'hF; flag_in = 4'hF; tick();
        check_eq("ovf_pulse", 32'(b_ovf),   32'h1);
        check_eq("ovf_depth", 32'(b_depth), 32'd2);
        check_eq("ovf_ipsr",  32'(b_ipsr),  32'd2);
        check_eq("ovf_apsr",  32'(b_apsr),  32'h0);
        check_eq("ovf_a_no",  32'(a_ovf),   32'h0);
        tick();
        check_eq("ovf_end",   32'(b_ovf),   32'h0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst_nest_depth", 32'(b_depth), 32'd0);
        check_eq("rst_nest_empty", 32'(b_empty), 32'h1);
        exc_return = 1'b1; tick();
        check_eq("unf_pulse", 32'(b_unf),  32'h1);
        check_eq("unf_ipsr",  32'(b_ipsr), 32'd0);
        tick();
        check_eq("unf_end",   32'(b_unf),  32'h0);
        exc_entry = 1'b1; exc_return = 1'b1; exc_num = 9'd5; tick();
        check_eq("tc_empty_unf",  32'(b_unf),   32'h1);
        check_eq("tc_empty_ipsr", 32'(b_ipsr),  32'd0);
        check_eq("tc_empty_depth",32'(b_depth), 32'd0);

        // Back-to-back push/pop
        exc_entry = 1'b1; exc_num = 9'd7; tick();
        check_eq("b2b_push", 32'(b_ipsr), 32'd7);
        exc_return = 1'b1; tick();
        check_eq("b2b_pop",  32'(b_ipsr), 32'd0);
        exc_entry = 1'b1; exc_num = 9'd9; tick();
        check_eq("b2b_push2", 32'(b_depth), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
